branch_history_table: RTL

//  Consumes the resolved branch outcome produced by the branch-decision stage and

---
 rtl/branch_history_table_if.sv | 39 +++
 rtl/branch_history_table.sv | 125 ++++++++++++
 2 files changed

// File: rtl/branch_history_table_if.sv
`default_nettype none
// ============================================================================
//  Module   : branch_history_table_if
//  Purpose  : Bundles the fetch-side prediction lookup and the execute-side
//             branch resolution / misprediction signals of the branch
//             history table into a single connection.
//  Revision : 1.0 - initial release
// ============================================================================
interface branch_history_table_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
);
    logic [PC_W-1:0]  fetch_pc;
    logic             predict_taken;
    logic             busy;
    logic             resolve_valid;
    logic [PC_W-1:0]  resolve_pc;
    logic             resolve_pred;
    logic             actual_outcome;
    logic [PC_W-1:0]  resolve_target;
    logic             mispredict;
    logic [PC_W-1:0]  redirect_pc;
    logic [CNT_W-1:0] mispredict_cnt;

    // Fetch / execute side: drives lookups and resolutions
    modport master (
        output fetch_pc, resolve_valid, resolve_pc, resolve_pred,
               actual_outcome, resolve_target,
        input  predict_taken, busy, mispredict, redirect_pc, mispredict_cnt
    );

    // Predictor side
    modport slave (
        input  fetch_pc, resolve_valid, resolve_pc, resolve_pred,
               actual_outcome, resolve_target,
        output predict_taken, busy, mispredict, redirect_pc, mispredict_cnt
    );
endinterface
`default_nettype wire

// File: rtl/branch_history_table.sv
`default_nettype none
// ============================================================================
//  Module   : branch_history_table
//  Purpose  : Table of 2-bit saturating counters indexed by word PC. Gives a
//             combinational taken/not-taken prediction to fetch, trains on
//             resolved branches and raises a registered one-cycle mispredict
//             pulse carrying the corrected redirect PC.
//  Revision : 1.0 - initial release
// ============================================================================
module branch_history_table #(
    parameter int IDX_W = 6,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    branch_history_table_if.slave   bus
);
    localparam int ENTRIES = 2**IDX_W;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [1:0]      WEAK_NT  = 2'b01;
    localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};
    localparam logic [PC_W-1:0]  PC_STEP  = {{(PC_W-3){1'b0}}, 3'b100};

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] init_ptr_q, init_ptr_d;
    logic [1:0]       table_q [ENTRIES];
    logic [1:0]       table_d [ENTRIES];
    logic             mispredict_q, mispredict_d;
    logic [PC_W-1:0]  redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0] mispredict_cnt_q, mispredict_cnt_d;

    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] resolve_idx;
    logic [1:0]       resolve_cnt;

    // PCs are word aligned, so the two low bits never take part in indexing
    assign fetch_idx   = bus.fetch_pc[IDX_W+1:2];
    assign resolve_idx = bus.resolve_pc[IDX_W+1:2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.fetch_pc[PC_W-1:IDX_W+2], bus.fetch_pc[1:0],
                              bus.resolve_pc[PC_W-1:IDX_W+2], bus.resolve_pc[1:0]};

    // State register and control/result flops, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_INIT;
            init_ptr_q       <= '0;
            mispredict_q     <= 1'b0;
            redirect_pc_q    <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            state_q          <= state_d;
            init_ptr_q       <= init_ptr_d;
            mispredict_q     <= mispredict_d;
            redirect_pc_q    <= redirect_pc_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    // Counter table storage; contents are defined by the INIT sweep, not reset
    always_ff @(posedge clk) begin
        table_q <= table_d;
    end

    // Next state: sweep every entry once, then run forever
    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        case (state_q)
            ST_INIT: begin
                init_ptr_d = init_ptr_q + 1'b1;
                if (init_ptr_q == LAST_IDX) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Table write: initialise during INIT, saturating train during RUN
    always_comb begin
        table_d     = table_q;
        resolve_cnt = table_q[resolve_idx];
        if (state_q == ST_INIT) begin
            table_d[init_ptr_q] = WEAK_NT;
        end else if (bus.resolve_valid) begin
            if (bus.actual_outcome) begin
                table_d[resolve_idx] = (resolve_cnt == 2'b11) ? resolve_cnt : resolve_cnt + 2'b01;
            end else begin
                table_d[resolve_idx] = (resolve_cnt == 2'b00) ? resolve_cnt : resolve_cnt - 2'b01;
            end
        end
    end

    // Mispredict detection, redirect target and saturating event count
    always_comb begin
        mispredict_d     = bus.resolve_valid && (state_q == ST_RUN) &&
                           (bus.resolve_pred != bus.actual_outcome);
        redirect_pc_d    = redirect_pc_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (mispredict_d) begin
            redirect_pc_d = bus.actual_outcome ? bus.resolve_target : bus.resolve_pc + PC_STEP;
            if (mispredict_cnt_q != {CNT_W{1'b1}}) begin
                mispredict_cnt_d = mispredict_cnt_q + 1'b1;
            end
        end
    end

    // Outputs: prediction reads the stored counter directly (no bypass)
    always_comb begin
        bus.busy           = (state_q == ST_INIT);
        bus.predict_taken  = (state_q == ST_RUN) ? table_q[fetch_idx][1] : 1'b0;
        bus.mispredict     = mispredict_q;
        bus.redirect_pc    = redirect_pc_q;
        bus.mispredict_cnt = mispredict_cnt_q;
    end
endmodule
`default_nettype wire
